// File: rtl/pixel_out_framer.sv
// Output framer: buffers the contrast pixel stream in a small FIFO, tags frame
// position markers and presents pixels on a valid/ready interface.
module pixel_out_framer #(
    parameter int unsigned PIX_W = 24,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIM_W = 12
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     start,
    input  logic [DIM_W-1:0]         img_width,
    input  logic [DIM_W-1:0]         img_height,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_pixel,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     out_eof,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned ENT_W = PIX_W + 3;
    localparam logic [AW:0]        P_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [DIM_W-1:0]   DIM_ONE = {{(DIM_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t state_q;
    state_t state_d;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [ENT_W-1:0] head;
    logic             empty;
    logic             full;
    logic             rd_en;
    logic             wr_en;
    logic             drop;
    logic             accept_start;
    logic             zero_start;
    logic             done_d;

    logic [DIM_W-1:0] w_lat;
    logic [DIM_W-1:0] h_lat;
    logic [DIM_W-1:0] w_last;
    logic [DIM_W-1:0] h_last;
    logic [DIM_W-1:0] col;
    logic [DIM_W-1:0] row;
    logic             tag_sof;
    logic             tag_eol;
    logic             tag_eof;

    // Extra MSB on the pointers separates full (MSBs differ) from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign out_valid = !empty;
    assign rd_en     = out_valid && out_ready;
    assign out_pixel = out_valid ? head[PIX_W-1:0] : '0;
    assign out_sof   = out_valid && head[PIX_W];
    assign out_eol   = out_valid && head[PIX_W+1];
    assign out_eof   = out_valid && head[PIX_W+2];
    assign busy      = (state_q != IDLE);

    assign w_last  = w_lat - DIM_ONE;
    assign h_last  = h_lat - DIM_ONE;
    assign tag_sof = (col == '0) && (row == '0);
    assign tag_eol = (col == w_last);
    assign tag_eof = tag_eol && (row == h_last);

    always_ff @(posedge clk) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        wr_en        = 1'b0;
        drop         = 1'b0;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((img_width != '0) && (img_height != '0)) begin
                        accept_start = 1'b1;
                        state_d      = ACTIVE;
                    end else begin
                        zero_start = 1'b1;
                        done_d     = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // A full FIFO still accepts when the head leaves in the same cycle.
                if (in_valid) begin
                    if (!full || rd_en) begin
                        wr_en = 1'b1;
                        if (tag_eof) state_d = DRAIN;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (rd_en && head[PIX_W+2]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            w_lat      <= '0;
            h_lat      <= '0;
            col        <= '0;
            row        <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_d;
            if (accept_start) begin
                w_lat    <= img_width;
                h_lat    <= img_height;
                col      <= '0;
                row      <= '0;
                overflow <= 1'b0;
            end else if (zero_start) begin
                overflow <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
            if (wr_en) begin
                if (tag_eol) begin
                    col <= '0;
                    row <= row + DIM_ONE;
                end else begin
                    col <= col + DIM_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + P_ONE;
            if (rd_en) rd_ptr <= rd_ptr + P_ONE;
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + P_ONE;
                2'b01:   fifo_level <= fifo_level - P_ONE;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {tag_eof, tag_eol, tag_sof, in_pixel};
    end

endmodule

// File: doc/pixel_out_framer.md
Name: pixel_out_framer

Overview:
- Downstream of the contrast stage. Consumes the contrast pixel stream (one pixel per cycle, qualified by in_valid).
- Buffers pixels in a small FIFO and presents them on a valid/ready output interface.
- Tags each pixel with frame position markers (start of frame, end of line, end of frame) from programmed image dimensions.
- Reports completion of each frame and sticky overflow when the output side stalls too long.

Parameters:
PIX_W, 24, pixel width (RGB 8:8:8 packed, same layout as contrast color_out)
DEPTH, 8, FIFO entries; power of 2, min 2
DIM_W, 12, width of image dimension inputs and position counters

Ports:
clk  in  1  clock, rising edge
resetN  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse: latch dimensions, begin a frame
img_width  in  DIM_W  pixels per line, sampled on start
img_height  in  DIM_W  lines per frame, sampled on start
in_valid  in  1  in_pixel valid this cycle (no backpressure upstream)
in_pixel  in  PIX_W  pixel from contrast stage
out_valid  out  1  out_pixel and markers valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_pixel  out  PIX_W  buffered pixel
out_sof  out  1  first pixel of frame
out_eol  out  1  last pixel of a line
out_eof  out  1  last pixel of frame
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a pixel was dropped this frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Synchronous active-low reset. All outputs 0, FIFO emptied, pointers/counters cleared, state IDLE.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - in_valid is ignored; nothing is written.
  - start with width!=0 and height!=0: latch W/H, clear col/row counters and overflow, go ACTIVE next cycle.
  - start with width==0 or height==0: stay IDLE, frame_done pulses next cycle, overflow cleared.
- ACTIVE, write side:
  - in_valid with FIFO not full: write {eof,eol,sof,pixel}.
  - sof = (col==0 && row==0); eol = (col==W-1); eof = eol && (row==H-1).
  - col increments on each accepted write; wraps to 0 at W-1 and row increments.
- ACTIVE, overflow:
  - in_valid with FIFO full and no simultaneous read: pixel dropped, counters unchanged, overflow set.
  - overflow holds until next accepted start or reset.
- ACTIVE, full with simultaneous read:
  - in_valid with FIFO full and out_valid & out_ready in the same cycle: write accepted, no overflow, level unchanged.
- ACTIVE to DRAIN: the accepted write tagged eof moves the state to DRAIN next cycle.
- DRAIN:
  - in_valid is ignored (no write, no overflow).
  - The handshake that reads the eof-tagged entry moves the state to IDLE, with frame_done=1 for exactly the following cycle.
- start while ACTIVE or DRAIN: ignored.
- Read side:
  - out_valid = FIFO not empty.
  - out_pixel/out_sof/out_eol/out_eof come from the head entry; forced to 0 when out_valid=0.
  - A handshake pops the head.
  - Data must be stable while out_valid & !out_ready.
- Latency: no bypass. A pixel written at edge N is visible on out_valid after edge N (one cycle input-to-output when empty).
- fifo_level: registered. +1 on write only, -1 on read only, unchanged on both or neither. Range 0..DEPTH.
- Pointers: wrap modulo DEPTH. Full/empty distinguished by an extra pointer bit.
- Reset mid-frame: everything discarded, returns to IDLE, no frame_done.

Test Plan:
- W=4, H=2, start, 8 consecutive in_valid, out_ready=1 ->
  - 8 outputs in order, each one cycle after input.
  - out_sof on pixel 0; out_eol on pixels 3 and 7; out_eof on pixel 7.
  - frame_done one cycle after pixel 7 handshake; busy 1 from cycle after start until IDLE.
- out_ready=0, W=16, H=1, 10 inputs ->
  - fifo_level reaches 8; pixels 8,9 dropped; overflow=1.
  - out_ready=1 then yields pixels 0..7 with no eof; state stays ACTIVE.
  - Next start clears overflow.
- FIFO full (level 8), in_valid and out_ready both 1 for 4 cycles ->
  - 4 pixels accepted, level stays 8, overflow stays 0, output order preserved.
- start with img_width=0, img_height=5 ->
  - frame_done pulse next cycle; busy stays 0; subsequent in_valid produces no output.
- W=4, H=2, resetN=0 after 5 inputs with out_ready=0 ->
  - all outputs 0, fifo_level 0, state IDLE, no frame_done.
  - New start then frames correctly from sof.
- In DRAIN, extra in_valid pulses and a start pulse ->
  - no writes, no overflow, start ignored.
  - frame_done after eof read, then next start accepted.
